// File: rtl/branch_predictor_if.sv
// Fetch/resolve port bundle of the branch predictor.
//   master : pipeline side, drives the IF lookup PC and the EX resolve/update fields.
//   slave  : predictor side, returns the prediction for the IF PC.
// Lookup : if_pc -> pred_hit, pred_taken, pred_target, pred_idx (combinational)
// Update : upd_valid, upd_pc, upd_idx, upd_is_branch, upd_taken, upd_target
interface branch_predictor_if #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 16
);
  localparam int unsigned Idx = $clog2(BTB_ENTRIES);

  // IF-stage lookup
  logic [XLEN-1:0] if_pc;
  logic            pred_hit;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic [Idx-1:0]  pred_idx;

  // EX-stage resolve
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic [Idx-1:0]  upd_idx;
  logic            upd_is_branch;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_idx, upd_is_branch, upd_taken, upd_target,
    input  pred_hit, pred_taken, pred_target, pred_idx
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_idx, upd_is_branch, upd_taken, upd_target,
    output pred_hit, pred_taken, pred_target, pred_idx
  );
endinterface

// File: rtl/branch_predictor.sv
// Dynamic branch predictor for the IF stage: a direct-mapped BTB (valid, tag, target,
// jump flag) plus a table of saturating counters indexed by PC (bimodal, GHR_BITS=0)
// or by PC XOR global history (gshare, GHR_BITS>0).
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bp    : branch_predictor_if.slave, combinational lookup from if_pc and
//           single-edge training from the EX-stage resolve fields
module branch_predictor #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BTB_ENTRIES = 16,
  parameter int unsigned CNT_BITS    = 2,
  parameter int unsigned GHR_BITS    = 0
) (
  input  logic               clk,
  input  logic               reset,
  branch_predictor_if.slave  bp
);

  localparam int unsigned Idx  = $clog2(BTB_ENTRIES);
  localparam int unsigned TagW = XLEN - Idx - 2;
  // Weakly not-taken start point; 0 for a 1-bit counter
  localparam logic [CNT_BITS-1:0] CntInit = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0] CntMax  = '1;

  // State
  logic [BTB_ENTRIES-1:0] r_valid;
  logic [BTB_ENTRIES-1:0] r_jump;
  logic [TagW-1:0]        r_tag    [BTB_ENTRIES];
  logic [XLEN-1:0]        r_target [BTB_ENTRIES];
  logic [CNT_BITS-1:0]    r_cnt    [BTB_ENTRIES];

  // Lookup path
  logic [Idx-1:0]  w_lk_bidx;
  logic [TagW-1:0] w_lk_tag;
  logic [Idx-1:0]  w_ghr_ext;
  logic [Idx-1:0]  w_pidx;
  logic            w_hit;
  logic            w_taken;

  // Update path
  logic [Idx-1:0]      w_up_bidx;
  logic [TagW-1:0]     w_up_tag;
  logic                w_btb_we;
  logic                w_cnt_we;
  logic [CNT_BITS-1:0] w_cnt_cur;
  logic [CNT_BITS-1:0] w_cnt_nxt;
  logic                w_unused_pc_lsbs;

  // Instructions are word aligned; the low PC bits carry no information here
  assign w_unused_pc_lsbs = ^{bp.if_pc[1:0], bp.upd_pc[1:0]};

  // ---------------------------------------------------------------------------
  // Global history (gshare only)
  // ---------------------------------------------------------------------------
  if (GHR_BITS > 0) begin : g_gshare
    logic [GHR_BITS-1:0] r_ghr;
    logic [GHR_BITS:0]   w_ghr_shift;
    logic                w_unused_ghr_msb;

    // Shift through a one-bit-wider vector so GHR_BITS=1 needs no special case
    assign w_ghr_shift      = {r_ghr, bp.upd_taken};
    assign w_unused_ghr_msb = w_ghr_shift[GHR_BITS];

    // Non-speculative: only resolved conditional branches shift in
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_ghr <= '0;
      end else if (w_cnt_we) begin
        r_ghr <= w_ghr_shift[GHR_BITS-1:0];
      end
    end

    assign w_ghr_ext = Idx'(r_ghr);
  end else begin : g_bimodal
    assign w_ghr_ext = '0;
  end

  // ---------------------------------------------------------------------------
  // Lookup (combinational, reads pre-update state; no bypass from the update port)
  // ---------------------------------------------------------------------------
  assign w_lk_bidx = bp.if_pc[Idx+1:2];
  assign w_lk_tag  = bp.if_pc[XLEN-1:Idx+2];
  assign w_pidx    = w_lk_bidx ^ w_ghr_ext;

  assign w_hit   = r_valid[w_lk_bidx] && (r_tag[w_lk_bidx] == w_lk_tag);
  assign w_taken = w_hit && (r_jump[w_lk_bidx] || r_cnt[w_pidx][CNT_BITS-1]);

  assign bp.pred_hit    = w_hit;
  assign bp.pred_taken  = w_taken;
  assign bp.pred_target = w_taken ? r_target[w_lk_bidx] : bp.if_pc + XLEN'(4);
  assign bp.pred_idx    = w_pidx;

  // ---------------------------------------------------------------------------
  // Update
  // ---------------------------------------------------------------------------
  assign w_up_bidx = bp.upd_pc[Idx+1:2];
  assign w_up_tag  = bp.upd_pc[XLEN-1:Idx+2];
  // Jumps count as taken regardless of upd_taken
  assign w_btb_we  = bp.upd_valid && (!bp.upd_is_branch || bp.upd_taken);
  assign w_cnt_we  = bp.upd_valid && bp.upd_is_branch;
  assign w_cnt_cur = r_cnt[bp.upd_idx];

  always_comb begin
    w_cnt_nxt = w_cnt_cur;
    if (bp.upd_taken) begin
      if (w_cnt_cur != CntMax) w_cnt_nxt = w_cnt_cur + CNT_BITS'(1);
    end else begin
      if (w_cnt_cur != '0) w_cnt_nxt = w_cnt_cur - CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        r_cnt[i] <= CntInit;
      end
    end else if (w_cnt_we) begin
      r_cnt[bp.upd_idx] <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
    end else if (w_btb_we) begin
      r_valid[w_up_bidx] <= 1'b1;
    end
  end

  // Tag/target/jump storage is never reset; r_valid gates every read of it
  always_ff @(posedge clk) begin
    if (w_btb_we) begin
      r_tag[w_up_bidx]    <= w_up_tag;
      r_target[w_up_bidx] <= bp.upd_target;
      r_jump[w_up_bidx]   <= !bp.upd_is_branch;
    end
  end

endmodule
